// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: sequencer states, control bundle and widths
// used by the hazard controller and its testbench.
package pipeline_hazard_ctrl_pkg;

  localparam logic [3:0] REG_ZERO    = 4'h0;
  localparam int         STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  // Field order fixes the packed bit layout, MSB first.
  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic idex_stall;
    logic exmem_stall;
    logic idex_bubble;
    logic memwb_bubble;
    logic ifid_flush;
    logic mem_req;
    logic halted;
    logic mem_err;
  } ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: hazard inputs from the
// stage registers and the stall/flush/status outputs back to them.
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  logic                   idex_memread;
  logic [3:0]             idex_dstReg;
  logic [3:0]             ifid_srcReg1;
  logic [3:0]             ifid_srcReg2;
  logic                   ifid_use_src2;
  logic                   exmem_memaccess;
  logic                   mem_ready;
  logic                   branch_taken;
  logic                   wb_halt;
  logic                   pc_stall;
  logic                   ifid_stall;
  logic                   idex_stall;
  logic                   exmem_stall;
  logic                   idex_bubble;
  logic                   memwb_bubble;
  logic                   ifid_flush;
  logic                   mem_req;
  logic                   halted;
  logic                   mem_err;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output idex_memread, idex_dstReg, ifid_srcReg1, ifid_srcReg2, ifid_use_src2,
           exmem_memaccess, mem_ready, branch_taken, wb_halt,
    input  pc_stall, ifid_stall, idex_stall, exmem_stall, idex_bubble,
           memwb_bubble, ifid_flush, mem_req, halted, mem_err, stall_cnt
  );

  modport slave (
    input  idex_memread, idex_dstReg, ifid_srcReg1, ifid_srcReg2, ifid_use_src2,
           exmem_memaccess, mem_ready, branch_taken, wb_halt,
    output pc_stall, ifid_stall, idex_stall, exmem_stall, idex_bubble,
           memwb_bubble, ifid_flush, mem_req, halted, mem_err, stall_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in ID/EX whose destination is
// read by the instruction in IF/ID. R0 is hard-wired zero and never conflicts.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       idex_memread,
  input  logic [3:0] idex_dst_reg,
  input  logic [3:0] ifid_src_reg1,
  input  logic [3:0] ifid_src_reg2,
  input  logic       ifid_use_src2,
  output logic       load_use
);

  assign load_use = idex_memread && (idex_dst_reg != REG_ZERO) &&
                    ((idex_dst_reg == ifid_src_reg1) ||
                     (ifid_use_src2 && (idex_dst_reg == ifid_src_reg2)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: memory-wait FSM with
// watchdog, load-use bubbles, branch flushes, halt and a stall-cycle counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned WD_W = $clog2(MEM_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

  state_t                 state, state_nxt;
  logic [WD_W-1:0]        wd;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic                   load_use;
  logic                   mem_stall;
  ctrl_t                  ctrl;

  hazard_detect u_hazard_detect (
    .idex_memread  (bus.idex_memread),
    .idex_dst_reg  (bus.idex_dstReg),
    .ifid_src_reg1 (bus.ifid_srcReg1),
    .ifid_src_reg2 (bus.ifid_srcReg2),
    .ifid_use_src2 (bus.ifid_use_src2),
    .load_use      (load_use)
  );

  assign mem_stall = bus.exmem_memaccess && !bus.mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state       <= ST_RUN;
      wd          <= '0;
      stall_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (state != ST_MEM_WAIT)
        wd <= '0;
      else
        wd <= wd + 1'b1;
      if (ctrl.pc_stall && (state != ST_HALTED) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (mem_stall)        state_nxt = ST_MEM_WAIT;
        else if (bus.wb_halt) state_nxt = ST_HALTED;
      end
      ST_MEM_WAIT: begin
        if (bus.mem_ready)     state_nxt = ST_RUN;
        else if (wd == WD_LAST) state_nxt = ST_ERROR;
      end
      default: state_nxt = state;
    endcase
  end

  // Outputs are forced low while reset is held so the pipeline sees no
  // request or stall even though its own inputs may still be active.
  always_comb begin
    // NOTE: default every field first so no path infers a latch.
    ctrl = '0;
    if (!rst) begin
      case (state)
        ST_RUN: begin
          ctrl.mem_req = bus.exmem_memaccess;
          if (mem_stall) begin
            ctrl.pc_stall     = 1'b1;
            ctrl.ifid_stall   = 1'b1;
            ctrl.idex_stall   = 1'b1;
            ctrl.exmem_stall  = 1'b1;
            ctrl.memwb_bubble = 1'b1;
          end else if (load_use) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.ifid_stall  = 1'b1;
            ctrl.idex_bubble = 1'b1;
          end else if (bus.branch_taken) begin
            ctrl.ifid_flush = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          ctrl.mem_req = 1'b1;
          if (!bus.mem_ready) begin
            ctrl.pc_stall     = 1'b1;
            ctrl.ifid_stall   = 1'b1;
            ctrl.idex_stall   = 1'b1;
            ctrl.exmem_stall  = 1'b1;
            ctrl.memwb_bubble = 1'b1;
          end
        end
        ST_HALTED: begin
          ctrl.halted     = 1'b1;
          ctrl.pc_stall   = 1'b1;
          ctrl.ifid_stall = 1'b1;
        end
        default: begin
          ctrl.mem_err     = 1'b1;
          ctrl.pc_stall    = 1'b1;
          ctrl.ifid_stall  = 1'b1;
          ctrl.idex_stall  = 1'b1;
          ctrl.exmem_stall = 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_stall     = ctrl.pc_stall;
  assign bus.ifid_stall   = ctrl.ifid_stall;
  assign bus.idex_stall   = ctrl.idex_stall;
  assign bus.exmem_stall  = ctrl.exmem_stall;
  assign bus.idex_bubble  = ctrl.idex_bubble;
  assign bus.memwb_bubble = ctrl.memwb_bubble;
  assign bus.ifid_flush   = ctrl.ifid_flush;
  assign bus.mem_req      = ctrl.mem_req;
  assign bus.halted       = ctrl.halted;
  assign bus.mem_err      = ctrl.mem_err;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each driven cycle queues its
// expected control bundle, compared against the outputs mid-cycle.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  // {pc,ifid,idex,exmem stall, idex_bubble, memwb_bubble, flush, mem_req, halted, mem_err}
  localparam ctrl_t C_NONE  = 10'b0000000000;
  localparam ctrl_t C_LU    = 10'b1100100000;
  localparam ctrl_t C_MEM   = 10'b1111010100;
  localparam ctrl_t C_REQ   = 10'b0000000100;
  localparam ctrl_t C_FLUSH = 10'b0000001000;
  localparam ctrl_t C_HALT  = 10'b1100000010;
  localparam ctrl_t C_ERR   = 10'b1111000001;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    total = 0;
  int    bad = 0;
  ctrl_t exp_q[$];

  pipeline_hazard_ctrl_if bus();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic ctrl_t observed();
    return {bus.pc_stall, bus.ifid_stall, bus.idex_stall, bus.exmem_stall,
            bus.idex_bubble, bus.memwb_bubble, bus.ifid_flush, bus.mem_req,
            bus.halted, bus.mem_err};
  endfunction

  task automatic set_in(input logic memread, input logic [3:0] dst,
                        input logic [3:0] src1, input logic [3:0] src2,
                        input logic use2, input logic memacc, input logic ready,
                        input logic br, input logic halt);
    bus.idex_memread    = memread;
    bus.idex_dstReg     = dst;
    bus.ifid_srcReg1    = src1;
    bus.ifid_srcReg2    = src2;
    bus.ifid_use_src2   = use2;
    bus.exmem_memaccess = memacc;
    bus.mem_ready       = ready;
    bus.branch_taken    = br;
    bus.wb_halt         = halt;
  endtask

  // Called at a falling edge with inputs already applied; ends at the next one.
  task automatic cyc(input string tag, input ctrl_t exp);
    ctrl_t e;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    check(tag, observed(), e);
    @(negedge clk);
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cyc("in_reset", C_NONE);
    rst = 1'b0;
    cyc("reset_idle", C_NONE);
    check("cnt_reset", bus.stall_cnt, 0);

    // load-use on src2, then src2 unused, R0, and src1 match
    set_in(1, 3, 5, 3, 1, 0, 0, 0, 0);
    cyc("lu_src2", C_LU);
    check("cnt_lu", bus.stall_cnt, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("lu_released", C_NONE);
    set_in(1, 3, 5, 3, 0, 0, 0, 0, 0);
    cyc("lu_src2_unused", C_NONE);
    set_in(1, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc("lu_r0", C_NONE);
    set_in(1, 7, 7, 2, 0, 0, 0, 0, 0);
    cyc("lu_src1", C_LU);

    // multi-cycle access: ready on cycle 4 after entry -> 4 stall cycles
    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("mem_wait", C_MEM);
    bus.mem_ready = 1'b1;
    cyc("mem_ready", C_REQ);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("mem_done", C_NONE);
    check("cnt_mem", bus.stall_cnt, 6);

    // zero-wait and back-to-back accesses
    set_in(0, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc("zero_wait_a", C_REQ);
    cyc("zero_wait_b", C_REQ);
    bus.mem_ready = 1'b0;
    cyc("b2b_stall_a", C_MEM);
    bus.mem_ready = 1'b1;
    cyc("b2b_ready_a", C_REQ);
    bus.mem_ready = 1'b0;
    cyc("b2b_stall_b", C_MEM);
    bus.mem_ready = 1'b1;
    cyc("b2b_ready_b", C_REQ);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("b2b_done", C_NONE);
    check("cnt_b2b", bus.stall_cnt, 8);

    // memory stall + load-use + branch together, then unwinding priorities
    set_in(1, 3, 3, 0, 0, 1, 0, 1, 0);
    cyc("simul", C_MEM);
    bus.mem_ready = 1'b1;
    cyc("simul_ready", C_REQ);
    set_in(1, 3, 3, 0, 0, 0, 0, 1, 0);
    cyc("lu_over_branch", C_LU);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("branch_flush", C_FLUSH);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("idle", C_NONE);
    check("cnt_simul", bus.stall_cnt, 10);

    // watchdog: entry cycle + 8 wait cycles, then sticky error
    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc("wdog_wait", C_MEM);
    cyc("wdog_err", C_ERR);
    bus.mem_ready = 1'b1;
    cyc("late_ready", C_ERR);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // error keeps pc_stall high: drive the counter into saturation
    for (int i = 0; i < 70000; i++) @(negedge clk);
    cyc("err_sticky", C_ERR);
    check("cnt_sat", bus.stall_cnt, 32'hFFFF);

    rst = 1'b1;
    cyc("rst_from_err", C_NONE);
    check("cnt_rst_clear", bus.stall_cnt, 0);
    rst = 1'b0;

    // halt: stalls persist, no requests, counter frozen
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("halt_seen", C_NONE);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("halted", C_HALT);
    set_in(1, 3, 3, 0, 0, 1, 0, 1, 0);
    cyc("halt_no_req", C_HALT);
    cyc("halt_hold", C_HALT);
    check("cnt_frozen", bus.stall_cnt, 0);

    // reset in the middle of a memory wait, inputs still active
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("pre_rst_stall", C_MEM);
    cyc("pre_rst_wait", C_MEM);
    rst = 1'b1;
    cyc("rst_mid_wait", C_NONE);
    check("cnt_rst_mid", bus.stall_cnt, 0);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("run_after_rst", C_FLUSH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage 16-bit pipeline. It drives the write-enable-inhibit (`stall`) and bubble/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazards: load-use data hazards, multi-cycle data-memory accesses (request/ready handshake), and taken-branch flushes. It also handles halt, a memory watchdog and a saturating stall-cycle counter.

## Interface
- `MEM_TIMEOUT`, default 64: WAIT cycles without `mem_ready` before the error state is entered (legal range 2–65535).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `idex_memread` in 1: instruction in ID/EX is LW.
- `idex_dstReg` in 4: destination register of the ID/EX instruction.
- `ifid_srcReg1`, `ifid_srcReg2` in 4 each: source registers of the IF/ID instruction.
- `ifid_use_src2` in 1: the IF/ID instruction reads `srcReg2`.
- `exmem_memaccess` in 1: instruction in EX/MEM is LW or SW.
- `mem_ready` in 1: data memory completes the current access this cycle.
- `branch_taken` in 1: ID-stage branch resolved taken.
- `wb_halt` in 1: HLT is in MEM/WB.
- `pc_stall`, `ifid_stall`, `idex_stall`, `exmem_stall` out 1 each: hold the corresponding register.
- `idex_bubble`, `memwb_bubble` out 1 each: load NOP/zero controls into ID/EX or MEM/WB.
- `ifid_flush` out 1: replace IF/ID with NOP.
- `mem_req` out 1: data-memory access request.
- `halted`, `mem_err` out 1 each: status flags.
- `stall_cnt` out 16: saturating count of cycles with `pc_stall`=1.

## Operation
- States are RUN, MEM_WAIT, HALTED and ERROR. The state and counters are registered; all control outputs are combinational from state and inputs.
- **RUN**
  - `mem_req` = `exmem_memaccess`.
  - If `exmem_memaccess`=1 and `mem_ready`=0: assert `pc_stall`, `ifid_stall`, `idex_stall`, `exmem_stall` and `memwb_bubble`; next state is MEM_WAIT.
  - If `exmem_memaccess`=1 and `mem_ready`=1: zero-wait access, no stall.
- **MEM_WAIT**
  - Assert `mem_req` and the full memory stall set (as in RUN).
  - On `mem_ready`=1: deassert all stalls in that same cycle; next state is RUN.
  - The watchdog counts MEM_WAIT cycles. When it reaches `MEM_TIMEOUT`-1 with `mem_ready`=0, the next state is ERROR.
- **Load-use hazard** (RUN only, no memory stall active): `idex_memread`=1, `idex_dstReg`≠0, and either `idex_dstReg`=`ifid_srcReg1`, or (`ifid_use_src2`=1 and `idex_dstReg`=`ifid_srcReg2`).
  - Response: `pc_stall`=1, `ifid_stall`=1, `idex_bubble`=1 for one cycle.
  - R0 never creates a hazard.
- **Branch flush** (RUN, no stall of any kind): `branch_taken`=1 gives `ifid_flush`=1. A branch that coincides with a stall is ignored; the ID stage re-presents it after the stall.
- **Priority:** ERROR > HALTED > memory stall > load-use > branch flush.
- **HALTED**
  - Entered from RUN when `wb_halt`=1 and no memory stall is active.
  - `halted`=1, `pc_stall`=1 and `ifid_stall`=1 permanently.
  - No memory requests are issued. Exit only by reset.
- **ERROR**
  - `mem_err`=1 and all four stalls are asserted. `mem_req`=0.
  - Sticky until reset.
- **`stall_cnt`** increments on every cycle with `pc_stall`=1, saturates at 0xFFFF, and does not count in HALTED.

## Timing
- Reset sets state RUN, watchdog 0, `stall_cnt` 0. With inputs inactive, every output is 0.
- Reset asserted mid-MEM_WAIT returns to RUN immediately. `mem_req` drops asynchronously with the state.
- Load-use stall length is exactly 1 cycle. A memory stall lasts N cycles, where `mem_ready` arrives on cycle N after entry (N≥0).
- Back-to-back memory instructions: completion cycle returns to RUN, and the next EX/MEM access is requested on the following cycle.
- The watchdog clears on every entry to MEM_WAIT.

## Structure
- A shared pipeline package holds:
  - the state enum,
  - the `REG_ZERO` constant (4'h0),
  - the `STALL_CNT_W` = 16 constant.
- One sub-module, `hazard_detect`: the purely combinational load-use comparator.
- The FSM, watchdog and `stall_cnt` stay in the top module.

## Test plan
- **Load-use:** `idex_memread`=1, `idex_dstReg`=3, `ifid_srcReg2`=3, `ifid_use_src2`=1 → one cycle of `pc_stall`, `ifid_stall` and `idex_bubble`; `stall_cnt`=1. Repeating with `idex_dstReg`=0 → no stall.
- **Multi-cycle memory:** `exmem_memaccess`=1, `mem_ready` rises on the 4th cycle → `mem_req`=1 for 4 cycles, stalls for 4 cycles (cleared in the ready cycle), `stall_cnt`=4. Zero-wait case (`mem_ready`=1 at once) → no stall.
- **Simultaneous events:** memory stall + load-use + `branch_taken` in the same cycle → only the memory stall set; `ifid_flush`=0 and `idex_bubble`=0.
- **Watchdog:** `MEM_TIMEOUT`=8, `mem_ready` never asserted → `mem_err`=1 after 8 stall cycles, `mem_req`=0, stalls held; a late `mem_ready` is ignored; reset clears everything.
- **Halt:** `wb_halt`=1 → `halted`=1 and `pc_stall`=1 persistently; `stall_cnt` frozen. Asserting `rst` mid-MEM_WAIT → all outputs 0 immediately.
- **Saturation:** force 70000 stall cycles → `stall_cnt`=0xFFFF.
